// File: rtl/alu_pkg.sv
// Shared ALU definitions: condition-code bit positions, opcodes for the
// divide/modulo operations and the sequential divider state encoding.
package alu_pkg;

    // Condition-code bit positions inside alucc / divcc.
    // For the divider, CC_C carries divide-by-zero (DZ) and CC_V carries overflow (OV).
    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_C = 1;
    localparam int CC_V = 0;

    // ALU opcodes served by the sequential divider.
    localparam logic [3:0] ALUOP_DIV = 4'b0011;
    localparam logic [3:0] ALUOP_MOD = 4'b0100;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor over WIDTH+1 bits and keep the difference when it
// does not go negative, shifting the matching quotient bit in at the bottom.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor always holds, so the shifted remainder fits WIDTH+1 bits and
    // the top bit of the trial difference is a reliable sign.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for the ALU DIV/DIVU/MOD operations.
// Handshake: a request is taken on any rising edge where start=1 and busy=0
// (state IDLE or DONE); done pulses for one cycle when valE/divcc become valid,
// and the results hold until the next accepted request completes.
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic             is_signed,
    input  logic             isMod,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] valE,
    output logic [3:0]       divcc
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             mod_q;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             fast_dz;
    logic             fast_ov;
    logic [WIDTH-1:0] fast_val;

    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;
    logic [WIDTH-1:0] fix_val;

    // Pack the flag nibble from a final, sign-fixed result.
    function automatic logic [3:0] make_cc(input logic [WIDTH-1:0] v,
                                           input logic             dz,
                                           input logic             ov);
        logic [3:0] cc;
        cc       = '0;
        cc[CC_N] = v[WIDTH-1];
        cc[CC_Z] = ~|v;
        cc[CC_C] = dz;
        cc[CC_V] = ov;
        return cc;
    endfunction

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Operand magnitudes and the two cases answered without iterating.
    always_comb begin
        abs_a    = (is_signed && valA[WIDTH-1]) ? -valA : valA;
        abs_b    = (is_signed && valB[WIDTH-1]) ? -valB : valB;
        fast_dz  = (valB == '0);
        fast_ov  = is_signed && (valA == MIN_VAL) && (valB == '1);
        fast_val = '0;
        if (fast_dz) begin
            fast_val = isMod ? valA : '1;
        end else if (fast_ov) begin
            fast_val = isMod ? '0 : MIN_VAL;
        end
    end

    // Sign fix-up applied to the outcome of the final iteration.
    always_comb begin
        fix_quo = neg_quo_q ? -step_quo : step_quo;
        fix_rem = neg_rem_q ? -step_rem : step_rem;
        fix_val = mod_q ? fix_rem : fix_quo;
    end

    // Control FSM with registered busy/done/valE/divcc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mod_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valE      <= '0;
            divcc     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mod_q <= isMod;
                        if (fast_dz || fast_ov) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            valE  <= fast_val;
                            divcc <= make_cc(fast_val, fast_dz, fast_ov && !isMod);
                        end else begin
                            state     <= CALC;
                            busy      <= 1'b1;
                            cnt       <= '0;
                            rem_q     <= '0;
                            quo_q     <= abs_a;
                            dvsr_q    <= abs_b;
                            neg_quo_q <= is_signed && (valA[WIDTH-1] ^ valB[WIDTH-1]);
                            neg_rem_q <= is_signed && valA[WIDTH-1];
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CALC: begin
                    // start is ignored here; the in-flight operands are untouched.
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        valE  <= fix_val;
                        divcc <= make_cc(fix_val, 1'b0, 1'b0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// requests, each predicted by an arithmetic reference model and checked by an
// independent monitor that pops a scoreboard queue whenever done pulses.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic         is_signed;
    logic         isMod;
    logic         busy;
    logic         done;
    logic [W-1:0] valE;
    logic [3:0]   divcc;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [35:0] exp_q[$];
    int          exp_cyc_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .valA      (valA),
        .valB      (valB),
        .is_signed (is_signed),
        .isMod     (isMod),
        .busy      (busy),
        .done      (done),
        .valE      (valE),
        .divcc     (divcc)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Reference: plain integer division with the ALU's special cases.
    function automatic logic [35:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s, input logic m);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic [W-1:0] v;
        logic         dz;
        logic         ov;
        dz = (b == 0);
        ov = 1'b0;
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            r  = 32'h0;
            ov = !m;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        v = m ? r : q;
        return {v, v[W-1], (v == 0), dz, ov};
    endfunction

    function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (b == 0) return 1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Driver: called at a negedge with busy low; the request is taken on the next posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic m);
        start     = 1'b1;
        valA      = a;
        valB      = b;
        is_signed = s;
        isMod     = m;
        exp_q.push_back(model(a, b, s, m));
        exp_cyc_q.push_back(cyc + latency(a, b, s));
        @(negedge clk);
        start = 1'b0;
        valA  = $urandom;
        valB  = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("wait_idle_timeout", 36'(busy), 36'(0));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {valE, divcc}, 36'h0);
            end else begin
                logic [35:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("valE", 36'(valE), 36'(e[35:4]));
                check("divcc", 36'(divcc), 36'(e[3:0]));
                check("latency", 36'(cyc), 36'(ec));
                check("busy_at_done", 36'(busy), 36'(0));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        valA      = '0;
        valB      = '0;
        is_signed = 1'b0;
        isMod     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 36'(busy), 36'(0));
        check("rst_done", 36'(done), 36'(0));
        check("rst_valE", 36'(valE), 36'(0));
        check("rst_divcc", 36'(divcc), 36'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        issue(32'd100, 32'd7, 1'b0, 1'b0); wait_idle();
        issue(32'd100, 32'd7, 1'b0, 1'b1); wait_idle();
        issue(-32'sd7, 32'd2, 1'b1, 1'b0); wait_idle();
        issue(-32'sd7, 32'd2, 1'b1, 1'b1); wait_idle();
        issue(32'd5, 32'd0, 1'b0, 1'b0);   wait_idle();
        issue(32'd5, 32'd0, 1'b0, 1'b1);   wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0); wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0); wait_idle();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0); wait_idle();
        issue(32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_idle();

        // start during CALC with different operands must be ignored.
        issue(32'd1000, 32'd9, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1; valA = 32'd77; valB = 32'd0; isMod = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Back-to-back: the second request is issued in the DONE cycle.
        issue(32'd12345, 32'd11, 1'b0, 1'b0); wait_idle();
        issue(32'd12345, 32'd11, 1'b0, 1'b1); wait_idle();
        repeat (2) @(negedge clk);

        // Reset in the middle of an iteration aborts it silently.
        issue(32'd999, 32'd4, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 36'(busy), 36'(0));
        check("abort_done", 36'(done), 36'(0));
        check("abort_valE", 36'(valE), 36'(0));
        exp_q.delete();
        exp_cyc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'd6, 32'd3, 1'b1, 1'b0); wait_idle();

        // Random requests with biased divisors and occasional idle gaps.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         s;
            logic         m;
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            issue(a, b, s, m);
            wait_idle();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Drain remaining expectations with a bound.
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) check("drain_timeout", 36'(exp_q.size()), 36'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
